// File: rtl/fifo_rptr_empty.sv
// -----------------------------------------------------------------------------
// fifo_rptr_empty
//   Read-side pointer and empty-flag controller for an asynchronous FIFO.
//   Brings the write-domain Gray write pointer into rclk through a two-flop
//   synchroniser. Keeps the binary and Gray read pointers and drives the
//   memory read address. Produces registered empty, level, data-valid,
//   underflow and (optionally) almost-empty status.
//
// Parameters
//   ADDR_SIZE     memory address width, DEPTH = 2**ADDR_SIZE
//   AEMPTY_THRESH almost-empty threshold in words (almost-empty build only)
//
// Ports
//   rclk       in   read clock
//   rrst_n     in   asynchronous active-low reset (read domain)
//   rinc       in   pop request, honoured only while rempty is low
//   wptr_gray  in   Gray write pointer from the write clock domain
//   raddr      out  memory read address (low bits of binary read pointer)
//   rptr       out  registered Gray read pointer for the write-side sync
//   rempty     out  registered empty flag
//   rvalid     out  memory read data holds the word popped last edge
//   rcount     out  words available as seen from the read side
//   rerr       out  single-cycle underflow pulse (rinc while empty)
//   raempty    out  almost-empty flag
//
// Build option
//   FIFO_RALMOST_EMPTY_EN  when defined, raempty is a registered
//                          "rcount <= AEMPTY_THRESH" flag (reset value 1);
//                          otherwise raempty is tied low.
// -----------------------------------------------------------------------------
module fifo_rptr_empty #(
  parameter int ADDR_SIZE     = 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 rinc,
  input  logic [ADDR_SIZE:0]   wptr_gray,
  output logic [ADDR_SIZE-1:0] raddr,
  output logic [ADDR_SIZE:0]   rptr,
  output logic                 rempty,
  output logic                 rvalid,
  output logic [ADDR_SIZE:0]   rcount,
  output logic                 rerr,
  output logic                 raempty
);

  localparam int PW = ADDR_SIZE + 1;

  // Synchroniser stages: plain flop chain so only one Gray bit can be
  // in flight at a time.
  logic [PW-1:0] rq1_q;
  logic [PW-1:0] rq2_q;

  logic [PW-1:0] rbin_q,   rbin_d;
  logic [PW-1:0] rgray_q,  rgray_d;
  logic [PW-1:0] rcount_q, rcount_d;
  logic          rempty_q, rempty_d;
  logic          rvalid_q, rvalid_d;
  logic          rerr_q,   rerr_d;
  logic          pop;

  // Synchronised write pointer converted back to binary. Each binary bit is
  // the XOR of all Gray bits at and above it.
  logic [PW-1:0] rq2_bin;

  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_gray2bin
      assign rq2_bin[gi] = ^rq2_q[PW-1:gi];
    end
  endgenerate

  always_comb begin
    pop      = rinc & ~rempty_q;
    rbin_d   = rbin_q + {{ADDR_SIZE{1'b0}}, pop};
    rgray_d  = rbin_d ^ (rbin_d >> 1);
    // Compare against the next pointer so empty rises on the same edge
    // that consumes the last visible word.
    rempty_d = (rgray_d == rq2_q);
    rcount_d = rq2_bin - rbin_d;
    rvalid_d = pop;
    rerr_d   = rinc & rempty_q;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rq1_q    <= '0;
      rq2_q    <= '0;
      rbin_q   <= '0;
      rgray_q  <= '0;
      rcount_q <= '0;
      rempty_q <= 1'b1;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      rq1_q    <= wptr_gray;
      rq2_q    <= rq1_q;
      rbin_q   <= rbin_d;
      rgray_q  <= rgray_d;
      rcount_q <= rcount_d;
      rempty_q <= rempty_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
    end
  end

  assign raddr  = rbin_q[ADDR_SIZE-1:0];
  assign rptr   = rgray_q;
  assign rempty = rempty_q;
  assign rvalid = rvalid_q;
  assign rcount = rcount_q;
  assign rerr   = rerr_q;

`ifdef FIFO_RALMOST_EMPTY_EN
  localparam logic [PW-1:0] AE_THRESH = PW'(AEMPTY_THRESH);

  logic raempty_q, raempty_d;

  // Uses the same next-cycle level as rcount so the two stay aligned.
  always_comb begin
    raempty_d = (rcount_d <= AE_THRESH);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      raempty_q <= 1'b1;
    end else begin
      raempty_q <= raempty_d;
    end
  end

  assign raempty = raempty_q;
`else
  // Feature absent: the flag is constant low whatever the threshold value.
  generate
    if (AEMPTY_THRESH >= 0) begin : g_no_aempty
      assign raempty = 1'b0;
    end else begin : g_no_aempty_neg
      assign raempty = 1'b0;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Self-checking bench for fifo_rptr_empty (ADDR_SIZE=4).
// A small behavioural memory registers rdata from raddr every rclk; each
// accepted pop pushes the expected word to a scoreboard queue, and the
// monitor pops and compares it whenever rvalid is high.
module tb_fifo_rptr_empty;

  localparam int AS = 4;
`ifdef FIFO_RALMOST_EMPTY_EN
  localparam bit AE_ON = 1'b1;
`else
  localparam bit AE_ON = 1'b0;
`endif

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic          rinc;
  logic [AS:0]   wptr_gray;
  logic [AS-1:0] raddr;
  logic [AS:0]   rptr;
  logic          rempty;
  logic          rvalid;
  logic [AS:0]   rcount;
  logic          rerr;
  logic          raempty;

  logic [7:0]    rdata;
  logic [7:0]    sb_q[$];
  int            errors = 0;
  int            checks = 0;
  logic [AS:0]   w;      // model write count
  logic [AS:0]   rb;     // model binary read pointer

  fifo_rptr_empty #(.ADDR_SIZE(AS), .AEMPTY_THRESH(2)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rinc      (rinc),
    .wptr_gray (wptr_gray),
    .raddr     (raddr),
    .rptr      (rptr),
    .rempty    (rempty),
    .rvalid    (rvalid),
    .rcount    (rcount),
    .rerr      (rerr),
    .raempty   (raempty)
  );

  always #5 rclk = ~rclk;

  function automatic logic [7:0] mem_word(input logic [AS-1:0] a);
    return 8'h30 + 8'({4'b0, a}) * 8'd7;
  endfunction

  function automatic logic [AS:0] gray(input logic [AS:0] b);
    return b ^ (b >> 1);
  endfunction

  // Behavioural memory read port.
  always @(posedge rclk) rdata <= mem_word(raddr);

  // Scoreboard monitor.
  always @(negedge rclk) begin
    if (rvalid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL rvalid_spurious: got rvalid=1 with rdata=%h, required no outstanding pop", rdata);
      end else begin
        logic [7:0] exp;
        exp = sb_q.pop_front();
        if (rdata !== exp) begin
          errors++;
          $display("FAIL pop_data: got %h required %h", rdata, exp);
        end else begin
          $display("pop data=%h", rdata);
        end
      end
    end
  end

  task automatic tick;
    @(posedge rclk);
    #1;
  endtask

  task automatic apply_reset;
    rinc      = 1'b0;
    wptr_gray = '0;
    rrst_n    = 1'b0;
    tick();
    tick();
    rrst_n = 1'b1;
    tick();
    w  = '0;
    rb = '0;
  endtask

  task automatic test_reset;
    rrst_n = 1'b1; rinc = 1'b0; wptr_gray = '0;
    #2 rrst_n = 1'b0;
    tick();
    tick();
    rrst_n = 1'b1;
    tick();
    w = '0; rb = '0;
    checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL reset_rempty: got %b required 1", rempty); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b required 0", rvalid); end
    checks++; if (rcount !== 5'd0) begin errors++; $display("FAIL reset_rcount: got %0d required 0", rcount); end
    checks++; if (raddr !== 4'd0) begin errors++; $display("FAIL reset_raddr: got %0d required 0", raddr); end
    checks++; if (rptr !== 5'd0) begin errors++; $display("FAIL reset_rptr: got %b required 0", rptr); end
    checks++; if (rerr !== 1'b0) begin errors++; $display("FAIL reset_rerr: got %b required 0", rerr); end
    checks++; if (raempty !== AE_ON) begin errors++; $display("FAIL reset_raempty: got %b required %b", raempty, AE_ON); end
    rinc = 1'b1;
    tick();
    $display("underflow pop attempt: rerr=%b raddr=%0d", rerr, raddr);
    checks++; if (rerr !== 1'b1) begin errors++; $display("FAIL underflow_rerr: got %b required 1", rerr); end
    checks++; if (raddr !== 4'd0) begin errors++; $display("FAIL underflow_raddr: got %0d required 0", raddr); end
    checks++; if (rptr !== 5'd0) begin errors++; $display("FAIL underflow_rptr: got %b required 0", rptr); end
    rinc = 1'b0;
    tick();
    checks++; if (rerr !== 1'b0) begin errors++; $display("FAIL underflow_rerr_clear: got %b required 0", rerr); end
  endtask

  task automatic test_fill_drain;
    w = 5'd3;
    wptr_gray = gray(w);
    for (int i = 0; i < 3 && rempty; i++) tick();
    checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL fill_rempty: got %b required 0 within 3 cycles", rempty); end
    checks++; if (rcount !== 5'd3) begin errors++; $display("FAIL fill_rcount: got %0d required 3", rcount); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (raddr !== 4'(k)) begin errors++; $display("FAIL drain_raddr_pre: got %0d required %0d", raddr, k); end
      sb_q.push_back(mem_word(rb[AS-1:0]));
      rinc = 1'b1;
      tick();
      rb++;
      $display("pop %0d: raddr=%0d rcount=%0d rempty=%b", k, raddr, rcount, rempty);
      checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL drain_rvalid: got %b required 1", rvalid); end
      checks++; if (raddr !== 4'(k + 1)) begin errors++; $display("FAIL drain_raddr: got %0d required %0d", raddr, k + 1); end
      checks++; if (rcount !== 5'(2 - k)) begin errors++; $display("FAIL drain_rcount: got %0d required %0d", rcount, 2 - k); end
      checks++; if (rempty !== (k == 2)) begin errors++; $display("FAIL drain_rempty: got %b required %b", rempty, k == 2); end
    end
    rinc = 1'b0;
    tick();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL drain_rvalid_clear: got %b required 0", rvalid); end
  endtask

  task automatic test_wrap;
    apply_reset();
    w = 5'd4;
    wptr_gray = gray(w);
    for (int i = 0; i < 3 && rempty; i++) tick();
    checks++; if (rcount !== 5'd4) begin errors++; $display("FAIL wrap_preload: got %0d required 4", rcount); end
    for (int n = 1; n <= 32; n++) begin
      sb_q.push_back(mem_word(rb[AS-1:0]));
      rinc = 1'b1;
      w++;
      wptr_gray = gray(w);
      tick();
      rb++;
      checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL wrap_rempty: pop %0d got %b required 0", n, rempty); end
      checks++; if (rerr !== 1'b0) begin errors++; $display("FAIL wrap_rerr: pop %0d got %b required 0", n, rerr); end
      if (n == 16) begin
        checks++; if (rptr !== 5'b11000) begin errors++; $display("FAIL wrap_rptr16: got %b required 11000", rptr); end
        checks++; if (raddr !== 4'd0) begin errors++; $display("FAIL wrap_raddr16: got %0d required 0", raddr); end
      end
      if (n == 32) begin
        checks++; if (rptr !== 5'b00000) begin errors++; $display("FAIL wrap_rptr32: got %b required 00000", rptr); end
        checks++; if (raddr !== 4'd0) begin errors++; $display("FAIL wrap_raddr32: got %0d required 0", raddr); end
      end
    end
    rinc = 1'b0;
    tick();
  endtask

  task automatic test_concurrent;
    apply_reset();
    w = 5'd4;
    wptr_gray = gray(w);
    for (int i = 0; i < 3 && rempty; i++) tick();
    checks++; if (rcount !== 5'd4) begin errors++; $display("FAIL conc_preload: got %0d required 4", rcount); end
    w = 5'd5;
    wptr_gray = gray(w);
    tick();
    tick();
    checks++; if (rcount !== 5'd4) begin errors++; $display("FAIL conc_before: got %0d required 4", rcount); end
    sb_q.push_back(mem_word(rb[AS-1:0]));
    rinc = 1'b1;
    tick();
    rb++;
    rinc = 1'b0;
    $display("concurrent pop: rcount=%0d raddr=%0d", rcount, raddr);
    checks++; if (rcount !== 5'd4) begin errors++; $display("FAIL conc_same_cycle: got %0d required 4", rcount); end
    checks++; if (raddr !== 4'd1) begin errors++; $display("FAIL conc_raddr: got %0d required 1", raddr); end
    tick();
    checks++; if (rcount !== 5'd4) begin errors++; $display("FAIL conc_after: got %0d required 4", rcount); end
    sb_q.push_back(mem_word(rb[AS-1:0]));
    rinc = 1'b1;
    tick();
    rb++;
    rinc = 1'b0;
    checks++; if (rcount !== 5'd3) begin errors++; $display("FAIL conc_track: got %0d required 3", rcount); end
    checks++; if (raddr !== 4'd2) begin errors++; $display("FAIL conc_track_raddr: got %0d required 2", raddr); end
  endtask

  task automatic test_reset_mid;
    w = rb + 5'd7;
    wptr_gray = gray(w);
    for (int i = 0; i < 3 && rcount != 5'd7; i++) tick();
    checks++; if (rcount !== 5'd7) begin errors++; $display("FAIL mid_preload: got %0d required 7", rcount); end
    rinc = 1'b1;
    #2;
    rrst_n = 1'b0;
    rinc = 1'b0;
    #1;
    $display("mid-burst reset: rempty=%b rcount=%0d raddr=%0d", rempty, rcount, raddr);
    checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL mid_rempty: got %b required 1", rempty); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid: got %b required 0", rvalid); end
    checks++; if (rcount !== 5'd0) begin errors++; $display("FAIL mid_rcount: got %0d required 0", rcount); end
    checks++; if (raddr !== 4'd0) begin errors++; $display("FAIL mid_raddr: got %0d required 0", raddr); end
    checks++; if (rptr !== 5'd0) begin errors++; $display("FAIL mid_rptr: got %b required 0", rptr); end
    checks++; if (rerr !== 1'b0) begin errors++; $display("FAIL mid_rerr: got %b required 0", rerr); end
    checks++; if (raempty !== AE_ON) begin errors++; $display("FAIL mid_raempty: got %b required %b", raempty, AE_ON); end
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;
    rb = '0;
    for (int i = 0; i < 3 && rempty; i++) tick();
    checks++; if (rcount !== w) begin errors++; $display("FAIL mid_resync: got %0d required %0d", rcount, w); end
    checks++; if (raddr !== 4'd0) begin errors++; $display("FAIL mid_first_raddr: got %0d required 0", raddr); end
    sb_q.push_back(mem_word(rb[AS-1:0]));
    rinc = 1'b1;
    tick();
    rb++;
    rinc = 1'b0;
    checks++; if (raddr !== 4'd1) begin errors++; $display("FAIL mid_next_raddr: got %0d required 1", raddr); end
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL mid_rvalid_pop: got %b required 1", rvalid); end
    tick();
  endtask

  task automatic test_aempty;
    logic [AS:0] exp_cnt;
    apply_reset();
    w = 5'd5;
    wptr_gray = gray(w);
    for (int i = 0; i < 3 && rempty; i++) tick();
    exp_cnt = 5'd5;
    checks++; if (rcount !== exp_cnt) begin errors++; $display("FAIL ae_rcount: got %0d required %0d", rcount, exp_cnt); end
    checks++; if (raempty !== (AE_ON && exp_cnt <= 5'd2)) begin errors++; $display("FAIL ae_flag: rcount=%0d got %b required %b", exp_cnt, raempty, AE_ON && exp_cnt <= 5'd2); end
    for (int k = 0; k < 3; k++) begin
      sb_q.push_back(mem_word(rb[AS-1:0]));
      rinc = 1'b1;
      tick();
      rb++;
      exp_cnt--;
      $display("aempty pop: rcount=%0d raempty=%b", rcount, raempty);
      checks++; if (rcount !== exp_cnt) begin errors++; $display("FAIL ae_rcount: got %0d required %0d", rcount, exp_cnt); end
      checks++; if (raempty !== (AE_ON && exp_cnt <= 5'd2)) begin errors++; $display("FAIL ae_flag: rcount=%0d got %b required %b", exp_cnt, raempty, AE_ON && exp_cnt <= 5'd2); end
    end
    rinc = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    w  = '0;
    rb = '0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_concurrent();
    test_reset_mid();
    test_aempty();
    tick();
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d outstanding required 0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
